// File: rtl/pwm_pkg.sv
// Shared FSM state type and default sizing for the PWM capture block.
package pwm_pkg;

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_SYNC = 2'd1,
        S_MEAS = 2'd2
    } state_t;

    localparam int DEF_CNT_W   = 4;
    localparam int DEF_TIMEOUT = 32;

endpackage

// File: rtl/pwm_in_sync.sv
// PWM input conditioning: 2-FF synchronizer, optional majority-of-3 deglitch
// (PWM_CAP_FILTER_EN), and a registered level/rise pair that are cycle-aligned.
module pwm_in_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_p_in,
    output logic o_s,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_s;
    logic r_rise;
    logic w_lvl;

`ifdef PWM_CAP_FILTER_EN
    logic r_h1;
    logic r_h2;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_h1 <= 1'b0;
            r_h2 <= 1'b0;
        end else begin
            r_h1 <= r_sync;
            r_h2 <= r_h1;
        end
    end

    // A level must be seen in two of the last three samples to pass.
    assign w_lvl = (r_sync & r_h1) | (r_sync & r_h2) | (r_h1 & r_h2);
`else
    assign w_lvl = r_sync;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_s    <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_meta <= i_p_in;
            r_sync <= r_meta;
            r_s    <= w_lvl;
            r_rise <= w_lvl & ~r_s;
        end
    end

    assign o_s    = r_s;
    assign o_rise = r_rise;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period between rising edges of P_IN and
// reports them with a 1-cycle VALID; optional deglitch via PWM_CAP_FILTER_EN.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter  int CNT_W   = DEF_CNT_W,
    parameter  int TIMEOUT = DEF_TIMEOUT,
    localparam int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             E,
    input  logic             P_IN,
    output logic [CNT_W-1:0] D_OUT,
    output logic [CW-1:0]    PER_OUT,
    output logic             VALID,
    output logic             STUCK,
    output state_t           DBG_STATE
);

    localparam logic [CNT_W-1:0] HI_MAX = '1;
    localparam logic [CNT_W-1:0] HI_ONE = CNT_W'(1);
    localparam logic [CW-1:0]    C_ONE  = CW'(1);
    localparam logic [CW-1:0]    C_LAST = CW'(TIMEOUT - 1);

    logic w_s;
    logic w_rise;

    state_t           r_state;
    logic [CW-1:0]    r_idle;
    logic [CW-1:0]    r_per;
    logic [CNT_W-1:0] r_hi;
    logic [CNT_W-1:0] r_d;
    logic [CW-1:0]    r_per_out;
    logic             r_valid;
    logic             r_stuck;

    pwm_in_sync u_in (
        .i_clk  (CLK),
        .i_rst  (RST),
        .i_p_in (P_IN),
        .o_s    (w_s),
        .o_rise (w_rise)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_OFF;
            r_idle    <= '0;
            r_per     <= '0;
            r_hi      <= '0;
            r_d       <= '0;
            r_per_out <= '0;
            r_valid   <= 1'b0;
            r_stuck   <= 1'b0;
        end else if (!E) begin
            // Disable drops partial counts; the last report stays readable.
            r_state <= S_OFF;
            r_idle  <= '0;
            r_per   <= '0;
            r_hi    <= '0;
            r_valid <= 1'b0;
            r_stuck <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_OFF: begin
                    r_state <= S_SYNC;
                    r_idle  <= '0;
                end
                S_SYNC: begin
                    if (w_rise) begin
                        r_state <= S_MEAS;
                        r_per   <= C_ONE;
                        r_hi    <= HI_ONE;
                        r_idle  <= '0;
                    end else if (r_idle == C_LAST) begin
                        r_d       <= w_s ? HI_MAX : '0;
                        r_per_out <= '0;
                        r_valid   <= 1'b1;
                        r_stuck   <= 1'b1;
                        r_idle    <= '0;
                    end else begin
                        r_idle <= r_idle + C_ONE;
                    end
                end
                S_MEAS: begin
                    // A rise on the timeout cycle still counts as a measurement.
                    if (w_rise) begin
                        r_d       <= r_hi;
                        r_per_out <= r_per;
                        r_valid   <= 1'b1;
                        r_stuck   <= 1'b0;
                        r_per     <= C_ONE;
                        r_hi      <= HI_ONE;
                    end else if (r_per == C_LAST) begin
                        r_d       <= w_s ? HI_MAX : '0;
                        r_per_out <= '0;
                        r_valid   <= 1'b1;
                        r_stuck   <= 1'b1;
                        r_state   <= S_SYNC;
                        r_idle    <= '0;
                        r_per     <= '0;
                        r_hi      <= '0;
                    end else begin
                        r_per <= r_per + C_ONE;
                        if (w_s && (r_hi != HI_MAX)) begin
                            r_hi <= r_hi + HI_ONE;
                        end
                    end
                end
                default: r_state <= S_OFF;
            endcase
        end
    end

    assign D_OUT     = r_d;
    assign PER_OUT   = r_per_out;
    assign VALID     = r_valid;
    assign STUCK     = r_stuck;
    assign DBG_STATE = r_state;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: directed PWM waveforms, expected reports queued up front
// and popped by a negedge monitor on every VALID strobe.
module tb_pwm_capture;
    import pwm_pkg::*;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 32;
    localparam int CW      = 6;
    localparam int W       = 19;   // {d[3:0], per[5:0], stuck, gap[7:0]}

    logic             CLK = 1'b0;
    logic             RST;
    logic             E;
    logic             P_IN;
    logic [CNT_W-1:0] D_OUT;
    logic [CW-1:0]    PER_OUT;
    logic             VALID;
    logic             STUCK;
    state_t           DBG_STATE;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_exp;
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_cyc = 0;
    int m_gap;

    pwm_capture #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .E         (E),
        .P_IN      (P_IN),
        .D_OUT     (D_OUT),
        .PER_OUT   (PER_OUT),
        .VALID     (VALID),
        .STUCK     (STUCK),
        .DBG_STATE (DBG_STATE)
    );

    // clock / reset-independent cycle counter
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // scoreboard monitor; a gap field of 0 means the spacing is not checked
    always @(negedge CLK) begin
        if (!RST && VALID) begin
            n_checks++;
            m_gap = cyc - last_cyc;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_valid: got d=%0d per=%0d stuck=%0d, required no report",
                         D_OUT, PER_OUT, STUCK);
            end else begin
                m_exp = exp_q.pop_front();
                if (D_OUT !== m_exp[18:15] || PER_OUT !== m_exp[14:9] || STUCK !== m_exp[8] ||
                    (m_exp[7:0] != 8'd0 && m_gap != int'(m_exp[7:0]))) begin
                    n_errors++;
                    $display("FAIL report: got d=%0d per=%0d stuck=%0d gap=%0d, required d=%0d per=%0d stuck=%0d gap=%0d",
                             D_OUT, PER_OUT, STUCK, m_gap,
                             m_exp[18:15], m_exp[14:9], m_exp[8], m_exp[7:0]);
                end
            end
            last_cyc = cyc;
        end
    end

    // driver tasks
    task automatic drive(input logic v, input int n);
        P_IN = v;
        repeat (n) @(negedge CLK);
    endtask

    task automatic pwm(input int hi, input int per, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, hi);
            drive(1'b0, per - hi);
        end
    endtask

    task automatic glitch_pwm(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 4);
            drive(1'b0, 3);
            drive(1'b1, 1);
            drive(1'b0, 8);
        end
    endtask

    task automatic push(input int d, input int per, input logic stuck, input int gap);
        exp_q.push_back({4'(d), 6'(per), stuck, 8'(gap)});
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(negedge CLK);
            k++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain_%s: got %0d reports outstanding, required 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic go_off();
        E    = 1'b0;
        P_IN = 1'b0;
        repeat (6) @(negedge CLK);
    endtask

    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: got no finish by 20000 cycles, required finish");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $fatal(1);
    end

    initial begin
        RST  = 1'b1;
        E    = 1'b0;
        P_IN = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_d", int'(D_OUT), 0);
        chk("rst_per", int'(PER_OUT), 0);
        chk("rst_valid", int'(VALID), 0);
        chk("rst_stuck", int'(STUCK), 0);
        chk("rst_state", int'(DBG_STATE), int'(S_OFF));
        RST = 1'b0;
        repeat (4) @(negedge CLK);

        // 14/16 waveform: reports from the second rise on
        push(14, 16, 1'b0, 0);
        for (int i = 0; i < 3; i++) push(14, 16, 1'b0, 16);
        E = 1'b1;
        pwm(14, 16, 5);
        go_off();
        drain("t1");
        chk("t1_off_hold_d", int'(D_OUT), 14);
        chk("t1_off_state", int'(DBG_STATE), int'(S_OFF));

        // held low: stuck report every 32 cycles
        push(0, 0, 1'b1, 0);
        push(0, 0, 1'b1, 32);
        push(0, 0, 1'b1, 32);
        E = 1'b1;
        repeat (100) @(negedge CLK);
        chk("t2_stuck_level", int'(STUCK), 1);
        chk("t2_state_sync", int'(DBG_STATE), int'(S_SYNC));
        go_off();
        drain("t2");
        chk("t2_off_stuck", int'(STUCK), 0);

        // held high, then 8/16 waveform clears STUCK
        push(15, 0, 1'b1, 0);
        push(15, 0, 1'b1, 32);
        push(8, 16, 1'b0, 0);
        push(8, 16, 1'b0, 16);
        E = 1'b1;
        drive(1'b1, 70);
        chk("t3_stuck_high", int'(STUCK), 1);
        chk("t3_d_high", int'(D_OUT), 15);
        drive(1'b0, 8);
        pwm(8, 16, 3);
        chk("t3_stuck_clear", int'(STUCK), 0);
        go_off();
        drain("t3");

        // 20/24 waveform: duty saturates
        push(15, 24, 1'b0, 0);
        push(15, 24, 1'b0, 24);
        push(15, 24, 1'b0, 24);
        E = 1'b1;
        pwm(20, 24, 4);
        go_off();
        drain("t4");

        // reset mid-period with E held high
        push(14, 16, 1'b0, 0);
        push(14, 16, 1'b0, 16);
        push(14, 16, 1'b0, 16);
        E = 1'b1;
        pwm(14, 16, 3);
        drive(1'b1, 6);
        P_IN = 1'b0;
        RST  = 1'b1;
        repeat (2) @(negedge CLK);
        drain("t5a_pre");
        chk("t5a_rst_d", int'(D_OUT), 0);
        chk("t5a_rst_per", int'(PER_OUT), 0);
        chk("t5a_rst_stuck", int'(STUCK), 0);
        chk("t5a_rst_state", int'(DBG_STATE), int'(S_OFF));
        RST = 1'b0;
        push(14, 16, 1'b0, 0);
        push(14, 16, 1'b0, 16);
        pwm(14, 16, 3);
        go_off();
        drain("t5a");

        // disable mid-period, then re-enable
        push(14, 16, 1'b0, 0);
        push(14, 16, 1'b0, 16);
        push(14, 16, 1'b0, 16);
        E = 1'b1;
        pwm(14, 16, 3);
        drive(1'b1, 6);
        E    = 1'b0;
        P_IN = 1'b0;
        repeat (4) @(negedge CLK);
        drain("t5b_pre");
        chk("t5b_off_d", int'(D_OUT), 14);
        chk("t5b_off_per", int'(PER_OUT), 16);
        chk("t5b_off_stuck", int'(STUCK), 0);
        chk("t5b_off_valid", int'(VALID), 0);
        chk("t5b_off_state", int'(DBG_STATE), int'(S_OFF));
        push(14, 16, 1'b0, 0);
        push(14, 16, 1'b0, 16);
        E = 1'b1;
        pwm(14, 16, 3);
        go_off();
        drain("t5b");

        // 4/16 waveform with a 1-cycle glitch in the low phase
`ifdef PWM_CAP_FILTER_EN
        push(4, 16, 1'b0, 0);
        push(4, 16, 1'b0, 16);
`else
        push(4, 7, 1'b0, 0);
        push(1, 9, 1'b0, 9);
        push(4, 7, 1'b0, 7);
        push(1, 9, 1'b0, 9);
        push(4, 7, 1'b0, 7);
`endif
        E = 1'b1;
        glitch_pwm(3);
        go_off();
        drain("t6");

        repeat (4) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
